// File: rtl/div_ctrl_pkg.sv
// Shared constants for the divider sequencer: controller state encodings and
// the start/stop and annul levels driven toward the radix-2 divider.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } div_state_t;

    localparam logic DIV_START    = 1'b1;
    localparam logic DIV_STOP     = 1'b0;
    localparam logic DIV_ANNUL    = 1'b1;
    localparam logic DIV_NO_ANNUL = 1'b0;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU between EX and the multi-cycle radix-2 divider.
// Optional macro DIV_FASTPATH_EN answers divisor==1 / dividend==0 without the divider.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     op1_i,
    input  logic [DATA_W-1:0]     op2_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  hilo_we_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  div_start_o,
    output logic                  div_annul_o,
    output logic                  div_signed_o,
    output logic [DATA_W-1:0]     div_op1_o,
    output logic [DATA_W-1:0]     div_op2_o,
    input  logic [2*DATA_W-1:0]   div_result_i,
    input  logic                  div_ready_i
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic              start_nxt, annul_nxt, signed_nxt;
    logic [DATA_W-1:0] op1_nxt, op2_nxt, hi_nxt, lo_nxt;

    // The pipeline is released on the RESP cycle, so only IDLE-accept and BUSY stall.
    assign stallreq_o = ((state == ST_IDLE) && req_i && !flush_i) || (state == ST_BUSY);
    assign hilo_we_o  = (state == ST_RESP) && !flush_i;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        start_nxt     = div_start_o;
        annul_nxt     = DIV_NO_ANNUL;
        signed_nxt    = div_signed_o;
        op1_nxt       = div_op1_o;
        op2_nxt       = div_op2_o;
        hi_nxt        = hi_o;
        lo_nxt        = lo_o;
        case (state)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    signed_nxt = signed_i;
                    op1_nxt    = op1_i;
                    op2_nxt    = op2_i;
`ifdef DIV_FASTPATH_EN
                    // x/1 = x rem 0 and 0/y = 0 rem 0 for both signednesses.
                    if ((op2_i == DATA_W'(1)) || (op1_i == '0)) begin
                        hi_nxt    = '0;
                        lo_nxt    = op1_i;
                        state_nxt = ST_RESP;
                    end else
`endif
                    begin
                        start_nxt = DIV_START;
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    start_nxt     = DIV_STOP;
                    annul_nxt     = DIV_ANNUL;
                    drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
                    state_nxt     = ST_DRAIN;
                end else if (div_ready_i) begin
                    hi_nxt    = div_result_i[2*DATA_W-1:DATA_W];
                    lo_nxt    = div_result_i[DATA_W-1:0];
                    start_nxt = DIV_STOP;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                // Keep start low long enough for the divider to fall back to free.
                drain_cnt_nxt = drain_cnt - CNT_W'(1);
                if (drain_cnt <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            drain_cnt    <= '0;
            div_start_o  <= DIV_STOP;
            div_annul_o  <= DIV_NO_ANNUL;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_cnt_nxt;
            div_start_o  <= start_nxt;
            div_annul_o  <= annul_nxt;
            div_signed_o <= signed_nxt;
            div_op1_o    <= op1_nxt;
            div_op2_o    <= op2_nxt;
            hi_o         <= hi_nxt;
            lo_o         <= lo_nxt;
        end
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer between the EX stage and the multi-cycle radix-2 divider (start/annul/ready handshake, 64-bit {remainder, quotient} result).
- Accepts DIV/DIVU requests from EX, holds the divider operands stable, raises the pipeline stall request, and returns HI/LO with a write enable.
- Handles flush mid-operation and drains the divider so the next request never sees a stale result.
- Instantiated next to the divider in the EX-level parent.

Parameters:
DATA_W, 32, operand width; only 32 is supported.
DRAIN_CYCLES, 2, cycles with start low after an abort before a new request is accepted; must be at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_i  in  1  EX holds a divide instruction; held stable while stallreq_o=1
signed_i  in  1  1 = DIV, 0 = DIVU
op1_i  in  32  dividend
op2_i  in  32  divisor
flush_i  in  1  pipeline flush; kills the current operation
stallreq_o  out  1  stall request to pipeline control (combinational)
hilo_we_o  out  1  one-cycle HI/LO write strobe
hi_o  out  32  remainder
lo_o  out  32  quotient
div_start_o  out  1  divider start (1 = start, 0 = stop); registered
div_annul_o  out  1  divider annul; registered one-cycle pulse
div_signed_o  out  1  latched signed_i
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor
div_result_i  in  64  divider result {rem, quot}
div_ready_i  in  1  divider result ready

Behaviour:
- Reset (rst=0, async): state IDLE. All registered outputs are 0: div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o, hi_o, lo_o. Drain counter is 0.
- States: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - req_i & !flush_i: latch signed_i, op1_i and op2_i into the div_* registers; set div_start_o=1; go to BUSY.
  - Otherwise: stay in IDLE.
- BUSY:
  - div_start_o and the div_* operand registers are held constant; the divider samples operands again at its final sign fix.
  - flush_i: div_start_o<=0, div_annul_o<=1 for one cycle, load the drain counter with DRAIN_CYCLES, go to DRAIN.
  - div_ready_i (and no flush): capture hi_o<=div_result_i[63:32] and lo_o<=div_result_i[31:0]; div_start_o<=0 (stop); go to RESP.
  - flush_i has priority over div_ready_i when both are high.
- RESP (one cycle):
  - hilo_we_o = !flush_i; hi_o and lo_o are valid.
  - Divider sees stop and returns to free; go to IDLE.
- DRAIN:
  - Counter decrements each cycle; div_start_o stays 0; go to IDLE when the counter reaches 1.
  - req_i is ignored during DRAIN.
- stallreq_o = (IDLE & req_i & !flush_i) | BUSY. It is 0 in RESP and DRAIN, so the pipeline advances on the RESP cycle.
- Back-to-back divides: a new request accepted in the IDLE cycle that follows RESP is legal.
- Latency: request seen in IDLE at cycle 0 → hilo_we_o at cycle 37.
  - Cycle 1: start high.
  - Cycles 2-34: divider iterating (32 iterations + sign fix).
  - Cycle 35: divider end state.
  - Cycle 36: div_ready_i high.
  - Cycle 37: RESP.
- Divisor 0: divider reports 0/0; hilo_we_o at cycle 5 with hi_o=lo_o=0.
- Reset mid-operation: controller returns to IDLE immediately. The divider has its own reset and the parent resets both together.
- No combinational path from div_ready_i to any output except through state.

Optional Feature:
DIV_FASTPATH_EN:
- Defined: in IDLE, a request with op2_i==1 or op1_i==0 bypasses the divider.
  - op2_i==1: lo_o=op1_i, hi_o=0, for both signed and unsigned.
  - op1_i==0: hi_o=lo_o=0.
  - Next state is RESP directly, so hilo_we_o is at cycle 1, stallreq_o is high only in cycle 0, and div_start_o stays 0.
- Undefined: all requests go through BUSY; no comparator logic is present.

Decomposition:
- State encodings (IDLE/BUSY/RESP/DRAIN) and the start/stop and annul constant values go in the shared defines header next to the existing divider constants.
- No sub-module; the fast-path comparator is a few lines inline.
- The divider is instantiated by the parent, not inside div_ctrl.

Test Plan:
1. DIVU 100/7 → hilo_we_o at cycle 37; lo_o=14, hi_o=2; stallreq_o high cycles 0-36.
2. DIV -100/7 → lo_o=0xFFFFFFF2 (-14), hi_o=0xFFFFFFFE (-2).
3. DIV 5/0 → hilo_we_o at cycle 5; hi_o=lo_o=0.
4. Flush at cycle 10 of 100/7 → div_annul_o pulse at cycle 11; no hilo_we_o; DRAIN for 2 cycles. A new request 9/3 immediately after flush is accepted only after drain and gives lo_o=3, hi_o=0 (no stale result).
5. Two back-to-back divides 100/7 then 81/9 → second accepted in the cycle after RESP; results 14/2 then 9/0.
6. DIV_FASTPATH_EN defined, DIV 0x80000000/1 → hilo_we_o at cycle 1, lo_o=0x80000000, hi_o=0, div_start_o never high. Undefined: same operation completes at cycle 37 with the same values.
